lane_drain_arbiter: RTL and testbench
=====================================

Name: lane_drain_arbiter

Overview:
- Shares one output stream between PARALLELISM per-lane width converters that sit downstream of the task dispatcher.
- Each lane holds whole tuples as a sequence of OUT_DATA_WIDTH beats. The arbiter grants one lane at a time, round-robin, and drains exactly one tuple per grant (tuple-atomic).
- It issues the lane read enables, absorbs the lane's 1-cycle read latency in a small skid buffer, and presents a valid/ready stream tagged with the source lane.

Parameters:
- PARALLELISM, 8, number of lanes; power of two.
- OUT_DATA_WIDTH, 32, beat width.
- BUF_DEPTH, 3, skid buffer entries; minimum 3.
- PARALLELISM_W, $clog2(PARALLELISM), lane index width.
- CNT_W, 32, tuple counter width.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- enable  in  1  allow new grants.
- lane_empty  in  PARALLELISM  per-lane converter empty.
- lane_valid  in  PARALLELISM  per-lane read data valid, 1 cycle after lane_rd_en.
- lane_dout  in  OUT_DATA_WIDTH x PARALLELISM  per-lane read data.
- lane_last  in  PARALLELISM  per-lane last beat of tuple, aligned with lane_valid.
- lane_rd_en  out  PARALLELISM  per-lane read enable; one-hot or zero.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_DATA_WIDTH  beat data.
- out_last  out  1  final beat of tuple.
- out_lane  out  PARALLELISM_W  source lane of beat.
- busy  out  1  state != IDLE or buffer non-empty.
- tuple_cnt  out  CNT_W  tuples fully emitted (out_last handshakes); wraps.
- protocol_err  out  1  sticky protocol error.

Behaviour:
- Reset: async on nrst low. Clears state to IDLE, rr_ptr=0, grant=0, in-flight flag=0, buffer occupancy=0, tuple_cnt=0, protocol_err=0. All outputs read 0 immediately. Reset mid-burst discards buffered beats.

State machine:
- IDLE:
  - When enable=1 and any lane_empty[i]=0, select the first non-empty lane scanning from rr_ptr upward, modulo PARALLELISM.
  - Register grant=g and set rr_ptr=(g+1)&(PARALLELISM-1). Next state is BURST.
  - No lane_rd_en is asserted in IDLE. The arbitration costs 1 cycle per tuple.
- BURST: lane_rd_en[g] = !lane_empty[g] & (occ + inflight < BUF_DEPTH) & !(lane_valid[g] & lane_last[g]).
  - inflight is the registered copy of the previous cycle's lane_rd_en[g].
  - occ counts at start of cycle; a same-cycle pop is ignored, so there is no combinational path from out_ready to lane_rd_en.
  - The last-beat term suppresses the read that would otherwise start the lane's next tuple.
  - When lane_valid[g] & lane_last[g], the beat is pushed and the next state is IDLE.
  - If the lane goes empty mid-tuple, stay in BURST with rd_en low.

Datapath:
- Every lane_valid[g] beat is pushed into the buffer as {data, last, g}. Space is guaranteed by the credit rule.
- out_valid = occ != 0; out_data, out_last and out_lane come from the buffer head.
- A pop happens on out_valid & out_ready. Push and pop may occur in the same cycle; occ is then unchanged.
- Steady-state throughput is 1 beat/clk with out_ready=1. Latency from lane_rd_en to out_valid is 2 cycles (1 lane + 1 buffer).
- tuple_cnt increments on out_valid & out_ready & out_last.
- enable=0 never aborts a tuple. BURST completes, then the block stays in IDLE.

Errors:
- protocol_err sets on lane_valid[i] with i != grant or state != BURST, or on lane_valid[g] without a matching inflight. It is cleared only by reset.
- Offending beats are dropped.

Test Plan:
- Lane 3 holds one 16-byte tuple (4 beats), out_ready=1 -> lane_rd_en[3] high exactly 4 consecutive cycles. out_valid is on 4 consecutive cycles with out_lane=3 and out_last on the 4th only. tuple_cnt=1, then busy falls.
- Lanes 0, 2 and 5 each hold one 2-beat tuple, rr_ptr=0 -> emitted lane order is 0,2,5 with 1 IDLE bubble between tuples. rr_ptr ends at 6. Rerun with rr_ptr=3 -> order is 5,0,2.
- Lane 1 holds an 8-beat tuple and out_ready drops after 2 accepted beats for 10 cycles -> lane_rd_en stops once occ+inflight=3. No beat is lost or duplicated, and all 8 data words arrive in order after out_ready returns.
- Lane 1 holds two tuples of 3 beats each -> lane_rd_en[1] is low in the cycle the first last beat returns. There is 1 IDLE cycle, lane 1 is regranted, and exactly 6 beats go out with 2 out_last pulses.
- Deassert enable during beat 2 of a 4-beat tuple on lane 6, while lane 7 is non-empty -> the lane-6 tuple completes and lane 7 is never granted while enable=0. Lane 7 is granted 1 cycle after enable returns.
- Assert nrst low mid-burst with occ=2 -> all outputs are 0 in the same cycle. Inject a lane_valid[4] beat while granted lane is 2 -> protocol_err=1 sticky and the beat is not emitted.

Source files
------------

// File: rtl/lane_drain_if.sv
// Lane-side read port and output stream of the lane drain arbiter.
// master = arbiter side, slave = lanes plus downstream consumer.
interface lane_drain_if #(
    parameter int PARALLELISM    = 8,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int PARALLELISM_W  = $clog2(PARALLELISM)
);
    logic [PARALLELISM-1:0]                     lane_empty;
    logic [PARALLELISM-1:0]                     lane_valid;
    logic [PARALLELISM-1:0][OUT_DATA_WIDTH-1:0] lane_dout;
    logic [PARALLELISM-1:0]                     lane_last;
    logic [PARALLELISM-1:0]                     lane_rd_en;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [OUT_DATA_WIDTH-1:0]                  out_data;
    logic                                       out_last;
    logic [PARALLELISM_W-1:0]                   out_lane;

    modport master (
        input  lane_empty, lane_valid, lane_dout, lane_last, out_ready,
        output lane_rd_en, out_valid, out_data, out_last, out_lane
    );

    modport slave (
        output lane_empty, lane_valid, lane_dout, lane_last, out_ready,
        input  lane_rd_en, out_valid, out_data, out_last, out_lane
    );
endinterface

// File: rtl/lane_drain_arbiter.sv
// Round-robin, tuple-atomic drain of PARALLELISM lane converters onto one
// valid/ready stream. Lane reads have 1-cycle latency; a small skid buffer
// plus a credit rule (occ + inflight < BUF_DEPTH) keeps it from overflowing.
module lane_drain_arbiter #(
    parameter int PARALLELISM    = 8,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int BUF_DEPTH      = 3,
    parameter int PARALLELISM_W  = $clog2(PARALLELISM),
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             enable,
    lane_drain_if.master     bus,
    output logic             busy,
    output logic [CNT_W-1:0] tuple_cnt,
    output logic             protocol_err
);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    typedef struct packed {
        logic [OUT_DATA_WIDTH-1:0] data;
        logic                      last;
        logic [PARALLELISM_W-1:0]  lane;
    } beat_t;

    state_t                   state;
    logic [PARALLELISM_W-1:0] rr_ptr;
    logic [PARALLELISM_W-1:0] grant;
    logic                     inflight;

    beat_t                    mem [BUF_DEPTH];
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [OCC_W-1:0]         occ;

    logic [PARALLELISM_W-1:0] pick;
    logic [PARALLELISM_W-1:0] idx;
    logic                     pick_vld;
    logic [PARALLELISM-1:0]   gmask;
    logic [PARALLELISM-1:0]   rd_en;
    logic                     lg_valid;
    logic                     lg_last;
    logic                     credit_ok;
    logic                     push;
    logic                     pop;
    logic                     err_now;
    beat_t                    head_beat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // First non-empty lane at or after rr_ptr, wrapping modulo PARALLELISM.
    always_comb begin
        pick_vld = 1'b0;
        pick     = rr_ptr;
        idx      = rr_ptr;
        for (int k = 0; k < PARALLELISM; k++) begin
            idx = rr_ptr + PARALLELISM_W'(k);
            if (!pick_vld && !bus.lane_empty[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    assign lg_valid  = bus.lane_valid[grant];
    assign lg_last   = bus.lane_last[grant];
    // occ is start-of-cycle; ignoring same-cycle pops keeps out_ready off the rd_en path.
    assign credit_ok = (int'(occ) + int'(inflight)) < BUF_DEPTH;
    assign push      = (state == BURST) && lg_valid && inflight;
    assign pop       = (occ != '0) && bus.out_ready;

    // Read enable for the granted lane; the last-beat term stops the read
    // that would start the lane's next tuple.
    always_comb begin
        rd_en = '0;
        gmask = '0;
        gmask[grant] = 1'b1;
        if (state == BURST && !bus.lane_empty[grant] && credit_ok && !(lg_valid && lg_last))
            rd_en[grant] = 1'b1;
    end

    assign bus.lane_rd_en = rd_en;

    // Stray beats: wrong lane, outside a burst, or with no read outstanding.
    assign err_now = (|(bus.lane_valid & ~gmask))
                   | ((state != BURST) & (|bus.lane_valid))
                   | ((state == BURST) & lg_valid & ~inflight);

    // Grant FSM: one IDLE cycle to arbitrate, BURST until the last beat returns.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en[grant];
            case (state)
                IDLE: begin
                    if (enable && pick_vld) begin
                        grant  <= pick;
                        rr_ptr <= pick + PARALLELISM_W'(1);
                        state  <= BURST;
                    end
                end
                BURST: begin
                    if (push && lg_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid buffer pointers and occupancy; reset discards buffered beats.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push)
                tail <= ptr_inc(tail);
            if (pop)
                head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Buffer storage; contents are don't-care while the entry is unoccupied.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= '{data: bus.lane_dout[grant], last: lg_last, lane: grant};
    end

    // Emitted-tuple counter and sticky protocol error.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tuple_cnt    <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (pop && head_beat.last)
                tuple_cnt <= tuple_cnt + CNT_W'(1);
            if (err_now)
                protocol_err <= 1'b1;
        end
    end

    // Head fields are gated so every output reads 0 while the buffer is empty.
    assign head_beat     = mem[head];
    assign bus.out_valid = (occ != '0);
    assign bus.out_data  = bus.out_valid ? head_beat.data : '0;
    assign bus.out_last  = bus.out_valid ? head_beat.last : 1'b0;
    assign bus.out_lane  = bus.out_valid ? head_beat.lane : '0;
    assign busy          = (state != IDLE) || (occ != '0);
endmodule

// File: tb/tb_lane_drain_arbiter.sv
// Randomized + directed bench for lane_drain_arbiter. Lanes are modelled as
// beat queues with 1-cycle read latency; expected output order is computed
// tuple-by-tuple from the round-robin rule over preloaded lane contents.
module tb_lane_drain_arbiter;
    localparam int P  = 8;
    localparam int W  = 32;
    localparam int D  = 3;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          enable;
    logic          busy;
    logic [CW-1:0] tuple_cnt;
    logic          protocol_err;

    lane_drain_if #(.PARALLELISM(P), .OUT_DATA_WIDTH(W)) bus ();

    lane_drain_arbiter #(
        .PARALLELISM(P), .OUT_DATA_WIDTH(W), .BUF_DEPTH(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .nrst(nrst), .enable(enable), .bus(bus),
        .busy(busy), .tuple_cnt(tuple_cnt), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [W:0]  lq [P][$];      // lane hardware contents {last, data}
    logic [W-1:0] mb [P][$];     // model: pending beats per lane
    int          mt [P][$];      // model: pending tuple lengths per lane
    logic [35:0] expq [$];       // expected {lane, last, data}
    int          exp_ptr = 0;
    int          exp_tuples;
    bit          exp_perr = 0;
    int          inj = -1;
    bit          rdy_rand = 0, en_rand = 0;
    logic        man_ready = 1'b1, man_en = 1'b1;
    int          cyc = 0;
    int          rd_cnt [P], rd_first [P], rd_last [P], lr_first [P];
    int          rd_total, acc_total, acc_first, acc_last, max_out;
    int          onehot_bad = 0, supp_bad = 0, extra_cnt = 0, bad_rd = 0;
    int          ord_q [$];
    logic [CW-1:0] tc0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Input driver for out_ready / enable (applied mid-cycle).
    initial begin
        forever begin
            bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : man_ready;
            enable        = en_rand  ? ($urandom_range(0, 7) != 0) : man_en;
            @(posedge clk);
            #2;
        end
    end

    // Lane converters: read pops a beat, returned the following cycle.
    initial begin
        logic [P-1:0]        v, l, e;
        logic [P-1:0][W-1:0] d;
        logic [W:0]          ent;
        bus.lane_valid = '0;
        bus.lane_last  = '0;
        bus.lane_dout  = '0;
        bus.lane_empty = '1;
        forever begin
            @(posedge clk);
            for (int i = 0; i < P; i++) begin
                v[i] = 1'b0; l[i] = 1'b0; d[i] = '0;
                if (bus.lane_rd_en[i]) begin
                    if (lq[i].size() > 0) begin
                        ent = lq[i].pop_front();
                        l[i] = ent[W]; d[i] = ent[W-1:0]; v[i] = 1'b1;
                    end else
                        bad_rd++;
                end else if (inj == i) begin
                    v[i] = 1'b1; l[i] = 1'b1; d[i] = 32'hBAD0_0BAD;
                end
                e[i] = (lq[i].size() == 0);
            end
            inj = -1;
            bus.lane_valid <= v;
            bus.lane_last  <= l;
            bus.lane_dout  <= d;
            bus.lane_empty <= e;
        end
    end

    // Monitor: read/return bookkeeping and scoreboard on accepted beats.
    always @(negedge clk) begin
        if (nrst) begin
            cyc++;
            if (bus.lane_rd_en != '0 && !$onehot(bus.lane_rd_en)) onehot_bad++;
            for (int i = 0; i < P; i++) begin
                if (bus.lane_rd_en[i]) begin
                    if (rd_cnt[i] == 0) rd_first[i] = cyc;
                    rd_last[i] = cyc;
                    rd_cnt[i]++;
                    rd_total++;
                end
                if (bus.lane_valid[i] && bus.lane_last[i]) begin
                    if (lr_first[i] < 0) lr_first[i] = cyc;
                    if (bus.lane_rd_en[i]) supp_bad++;
                end
            end
            if (rd_total - acc_total > max_out) max_out = rd_total - acc_total;
            if (bus.out_valid && bus.out_ready) begin
                if (acc_total == 0) acc_first = cyc;
                acc_last = cyc;
                acc_total++;
                if (bus.out_last) ord_q.push_back(int'(bus.out_lane));
                if (expq.size() == 0)
                    extra_cnt++;
                else
                    chk("beat", {bus.out_lane, bus.out_last, bus.out_data}, expq.pop_front());
            end
        end
    end

    task automatic clr();
        for (int i = 0; i < P; i++) begin
            rd_cnt[i] = 0; rd_first[i] = -1; rd_last[i] = -1; lr_first[i] = -1;
        end
        rd_total = 0; acc_total = 0; acc_first = -1; acc_last = -1; max_out = 0;
        extra_cnt = 0; exp_tuples = 0;
        ord_q.delete();
        tc0 = tuple_cnt;
    endtask

    task automatic load(input int lane, input int n);
        logic [W-1:0] dat;
        for (int b = 0; b < n; b++) begin
            dat = $urandom;
            lq[lane].push_back({(b == n - 1), dat});
            mb[lane].push_back(dat);
        end
        mt[lane].push_back(n);
    endtask

    // Reference: grant first lane with a pending tuple from exp_ptr, drain one tuple.
    task automatic predict();
        int g, n;
        bit any;
        logic [2:0] gl;
        forever begin
            any = 0; g = 0;
            for (int k = 0; k < P; k++)
                if (!any && mt[(exp_ptr + k) % P].size() > 0) begin
                    any = 1; g = (exp_ptr + k) % P;
                end
            if (!any) break;
            n  = mt[g].pop_front();
            gl = 3'(g);
            for (int b = 0; b < n; b++)
                expq.push_back({gl, (b == n - 1), mb[g].pop_front()});
            exp_tuples++;
            exp_ptr = (g + 1) % P;
        end
    endtask

    function automatic int lanes_idle();
        for (int i = 0; i < P; i++)
            if (lq[i].size() != 0) return 0;
        return 1;
    endfunction

    function automatic int ord_code();
        int c = 0;
        foreach (ord_q[i]) c = c * 10 + ord_q[i] + 1;
        return c;
    endfunction

    task automatic drain(input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            if (expq.size() == 0 && !bus.out_valid && !busy && lanes_idle() == 1) done = 1;
        end
        chk("drain_done", done, 1);
        chk("tuples", tuple_cnt - tc0, exp_tuples);
        chk("extra_beats", extra_cnt, 0);
        chk("credit", (max_out <= D), 1);
        chk("perr", protocol_err, exp_perr);
    endtask

    task automatic wait_rd(input int lane, input int n, output bit ok);
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #1;
            if (rd_cnt[lane] >= n) ok = 1;
        end
    endtask

    task automatic flush_lanes();
        for (int i = 0; i < P; i++) begin
            lq[i].delete(); mb[i].delete(); mt[i].delete();
        end
        expq.delete();
        exp_ptr = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_rd_en", bus.lane_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tuple_cnt", tuple_cnt, 0);
        chk("rst_perr", protocol_err, 0);
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Lanes 0,2,5 from rr_ptr 0
        clr(); load(0, 2); load(2, 2); load(5, 2); predict(); drain(300);
        chk("order_025", ord_code(), 136);
        // rr_ptr should now be 6: lane 7 precedes lane 5
        clr(); load(5, 1); load(7, 1); predict(); drain(300);
        chk("order_75", ord_code(), 86);
        // lane 2 alone leaves rr_ptr at 3
        clr(); load(2, 1); predict(); drain(300);
        clr(); load(0, 2); load(2, 2); load(5, 2); predict(); drain(300);
        chk("order_502", ord_code(), 613);

        // Lane 3, one 4-beat tuple
        clr(); load(3, 4); predict(); drain(300);
        chk("l3_rd_cnt", rd_cnt[3], 4);
        chk("l3_rd_span", rd_last[3] - rd_first[3], 3);
        chk("l3_out_cnt", acc_total, 4);
        chk("l3_out_span", acc_last - acc_first, 3);
        chk("l3_latency", acc_first - rd_first[3], 2);
        chk("l3_busy", busy, 0);

        // Enable dropped during beat 2 of lane 6 with lane 7 waiting
        clr(); load(6, 4); load(7, 2); predict();
        wait_rd(6, 2, ok);
        chk("en_wait", ok, 1);
        man_en = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("en_l6_done", tuple_cnt - tc0, 1);
        chk("en_l7_held", rd_cnt[7], 0);
        chk("en_idle", busy, 0);
        man_en = 1'b1;
        @(posedge clk); #1;
        chk("en_regrant", bus.lane_rd_en, 8'h80);
        drain(300);

        // Lane 1 8-beat tuple with a 10-cycle stall after 2 beats
        clr(); load(1, 8); predict();
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #1;
            if (acc_total >= 2) ok = 1;
        end
        man_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_acc", acc_total, 2);
        chk("stall_out", max_out, 3);
        chk("stall_rd", rd_cnt[1], 5);
        man_ready = 1'b1;
        drain(300);

        // Lane 1 with two 3-beat tuples back to back
        clr(); load(1, 3); load(1, 3); predict(); drain(300);
        chk("two_rd_cnt", rd_cnt[1], 6);
        chk("two_rd_span", rd_last[1] - rd_first[1], 7);
        chk("two_last_ret", lr_first[1] - rd_first[1], 3);
        chk("two_out_cnt", acc_total, 6);

        // Reset mid-burst with two beats buffered
        clr(); load(2, 8);
        mt[2].delete(); mb[2].delete();
        man_ready = 1'b0;
        wait_rd(2, 3, ok);
        chk("rstm_wait", ok, 1);
        chk("rstm_valid_pre", bus.out_valid, 1);
        nrst = 1'b0;
        #1;
        chk("rstm_out_valid", bus.out_valid, 0);
        chk("rstm_out_data", bus.out_data, 0);
        chk("rstm_out_misc", {bus.out_last, bus.out_lane}, 0);
        chk("rstm_rd_en", bus.lane_rd_en, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_tuple_cnt", tuple_cnt, 0);
        flush_lanes();
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        man_ready = 1'b1;

        // Stray beat on lane 4 while lane 2 is granted
        clr(); load(2, 3); predict();
        wait_rd(2, 1, ok);
        chk("err_wait", ok, 1);
        inj = 4;
        exp_perr = 1;
        drain(300);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", protocol_err, 1);
        nrst = 1'b0;
        #1;
        chk("err_rst", protocol_err, 0);
        flush_lanes();
        exp_perr = 0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;

        // Random traffic, random backpressure and enable
        for (int it = 0; it < 40; it++) begin
            clr();
            rdy_rand = ($urandom_range(0, 1) == 1);
            en_rand  = (it % 3 == 0);
            for (int ln = 0; ln < P; ln++) begin
                int nt;
                nt = $urandom_range(0, 2);
                for (int t = 0; t < nt; t++) load(ln, $urandom_range(1, 5));
            end
            predict();
            drain(3000);
            rdy_rand = 0;
            en_rand  = 0;
        end

        chk("onehot", onehot_bad, 0);
        chk("rd_empty_lane", bad_rd, 0);
        chk("last_suppress", supp_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
